core_scheduler: RTL

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/core_scheduler.sv
// Per-core pipeline sequencer: IDLE -> FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE.
// Define SCHED_WAIT_TIMEOUT_EN to add an 8-bit WAIT watchdog that ends the block with timeout=1.
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [2:0]                           fetcher_state,
    input  logic                                 decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic                                 done,
    output logic                                 timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

    state_t             state;
    state_t             state_next;
    logic               lanes_busy;
    logic               wd_expired;
    logic [PC_BITS-1:0] pc_converged;

    // Threads are assumed convergent, so the last lane's next PC speaks for the block.
    assign pc_converged = next_pc[PC_BITS*(THREADS_PER_BLOCK-1) +: PC_BITS];
    assign core_state   = state;

    always_comb begin
        lanes_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (lsu_state[2*i +: 2] == LSU_REQUESTING || lsu_state[2*i +: 2] == LSU_WAITING)
                lanes_busy = 1'b1;
        end
    end

`ifdef SCHED_WAIT_TIMEOUT_EN
    logic [7:0] wd_count;
    logic       timeout_q;

    assign wd_expired = (state == S_WAIT) && lanes_busy && (wd_count == 8'hFF);
    assign timeout    = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            // REQUEST is the only way into WAIT, so clearing there clears on entry.
            if (state == S_REQUEST)
                wd_count <= 8'd0;
            else if (state == S_WAIT && lanes_busy && wd_count != 8'hFF)
                wd_count <= wd_count + 8'd1;
            if (wd_expired)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_FETCH;
            S_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_next = S_DECODE;
            S_DECODE:  state_next = S_REQUEST;
            S_REQUEST: state_next = S_WAIT;
            S_WAIT: begin
                if (!lanes_busy)
                    state_next = S_EXECUTE;
                else if (wd_expired)
                    state_next = S_DONE;
            end
            S_EXECUTE: state_next = S_UPDATE;
            S_UPDATE:  state_next = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        current_pc <= '0;
                        done       <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wd_expired)
                        done <= 1'b1;
                end
                S_UPDATE: begin
                    if (decoded_ret)
                        done <= 1'b1;
                    else
                        current_pc <= pc_converged;
                end
                default: ;
            endcase
        end
    end

endmodule
